seq_checker: RTL and testbench
==============================

Name: seq_checker

Overview:
- Downstream monitor for the 3-bit sequence counter output, which cycles 0→2→5→3→4→0 and holds 0 while its own reset is asserted.
- Samples the counter value, checks every transition against the legal successor function, and declares lock after LOCK_CNT consecutive correct transitions.
- Reports errors as a single-cycle pulse plus a saturating error count, and counts completed sequence cycles.
- Sits between the counter and the status/debug logic.

Parameters:
- W, 32, width of the sampled counter value (matches the counter output width).
- LOCK_CNT, 3, consecutive correct transitions required to assert locked; legal range 1..15.
- ERR_W, 8, width of err_count.
- CYC_W, 16, width of cycle_count.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  sample enable; when 0, all state and outputs hold.
- in_val  input  W  counter value to check.
- clr_err  input  1  synchronous clear of err_count.
- locked  output  1  sequence lock indicator.
- err_pulse  output  1  one-cycle error flag.
- err_count  output  ERR_W  saturating error count.
- cycle_count  output  CYC_W  completed 4→0 wraps while locked, modulo 2^CYC_W.
- expected  output  3  successor of the last legal sample; 0 in IDLE.

Behaviour:
- Interface fixed: single clock clk; rst is asynchronous and active-high. rst asserted forces immediately, without waiting for a clock edge: state=IDLE, locked=0, err_pulse=0, err_count=0, cycle_count=0, expected=0, run=0, prev=0.
- All outputs are registers updated on the same clk edge that samples in_val with en=1.
- Legal values are {0,2,5,3,4}. A value is illegal if in_val[W-1:3]≠0 or in_val[2:0]∈{1,6,7}.
- succ(): 0→2, 2→5, 5→3, 3→4, 4→0.
- A sample is "good" if in_val==succ(prev). A sample is a "hold" if prev==0 and in_val==0; a hold is neither good nor error, and state is unchanged. Any other sample is an "error". A repeat of a nonzero value is an error.
- FSM states: IDLE, HUNT, LOCKED.
  - IDLE: legal sample → HUNT, prev=in_val, run=0. Illegal sample → error, stay IDLE.
  - HUNT: good sample → run+1 and prev=in_val; if run+1==LOCK_CNT → LOCKED and locked=1 on that edge. Hold → no change. Error → err; if the sample is legal, stay HUNT with run=0 and prev=in_val, else go to IDLE.
  - LOCKED: good sample → stay; if prev==4 and in_val==0, cycle_count+1 (wraps). Hold → stay. Error → locked=0 on that edge, then HUNT or IDLE using the same rule as in HUNT.
- err_pulse is 1 for exactly the cycle following an error edge. Back-to-back errors keep it high continuously.
- err_count increments on each error and saturates at 2^ERR_W−1.
- If clr_err coincides with an error, err_count=1. If clr_err occurs with no error, err_count=0.
- cycle_count never increments outside LOCKED.
- en=0: the edge is ignored entirely and err_pulse goes to 0.

Decomposition:
- Shared package seq_pkg holds:
  - counter state constants SEQ_S0..SEQ_S4 = 0,2,5,3,4;
  - succ function and is_legal function;
  - checker state encoding IDLE/HUNT/LOCKED (2-bit).
- One natural sub-module, sat_counter (parameter N; inc, clr; saturating at all-ones; asynchronous rst), used for err_count.

Test Plan:
- Lock and cycle count: rst pulse, then en=1 and in_val=0,2,5,3,4,0,2 → locked=1 after the 4th sample (3 good transitions); cycle_count=1 after the 6th sample; err_count=0 throughout.
- Illegal value while locked: in_val=6 → err_pulse high for 1 cycle, err_count=1, locked=0, state IDLE, expected=0. Then 0,2,5,3 → locked=1 again.
- Hold of 0: while locked, in_val=0 for 5 samples → no error, locked stays 1. Resuming with 2 → still locked.
- Repeated value and upper bits: in_val=5,5 → error, HUNT, prev=5, run=0. Then in_val=32'h0000_0102 → error, IDLE.
- Saturation and clear: ERR_W=8, 260 illegal samples → err_count=255. clr_err together with an illegal sample → err_count=1. clr_err alone → 0.
- Asynchronous reset: assert rst mid-cycle while LOCKED with cycle_count=3 → all outputs 0 before the next clk edge. Deassert rst with en=0 for 2 cycles → outputs remain 0.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the sequence checker: counter state values,
// successor/legality helpers and the checker state encoding.
package seq_pkg;

  localparam logic [2:0] SEQ_S0 = 3'd0;
  localparam logic [2:0] SEQ_S1 = 3'd2;
  localparam logic [2:0] SEQ_S2 = 3'd5;
  localparam logic [2:0] SEQ_S3 = 3'd3;
  localparam logic [2:0] SEQ_S4 = 3'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } chk_state_e;

  function automatic logic [2:0] succ(input logic [2:0] v);
    logic [2:0] r;
    case (v)
      SEQ_S0:  r = SEQ_S1;
      SEQ_S1:  r = SEQ_S2;
      SEQ_S2:  r = SEQ_S3;
      SEQ_S3:  r = SEQ_S4;
      SEQ_S4:  r = SEQ_S0;
      default: r = SEQ_S0;
    endcase
    return r;
  endfunction

  // upper_zero reports that every bit above [2:0] of the sample is clear
  function automatic logic is_legal(input logic upper_zero, input logic [2:0] v);
    logic ok;
    case (v)
      3'd1, 3'd6, 3'd7: ok = 1'b0;
      default:          ok = 1'b1;
    endcase
    return upper_zero & ok;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear together with
// increment yields 1 so the triggering event is still counted.
module sat_counter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [N-1:0] q
);

  localparam logic [N-1:0] MAX = {N{1'b1}};

  // count register: clear has priority, then saturating increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= {N{1'b0}};
    end else if (clr) begin
      q <= inc ? N'(1) : N'(0);
    end else if (inc && (q != MAX)) begin
      q <= q + N'(1);
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/seq_checker.sv
// Monitor for the 0->2->5->3->4 sequence counter: tracks lock, flags
// transition errors and counts completed cycles while locked.
module seq_checker
  import seq_pkg::*;
#(
  parameter int W        = 32,
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8,
  parameter int CYC_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [W-1:0]     in_val,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [CYC_W-1:0] cycle_count,
  output logic [2:0]       expected
);

  localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);

  chk_state_e state_r;
  logic [2:0] prev_r;
  logic [3:0] run_r;

  logic [2:0] low_s;
  logic       legal_s;
  logic       good_s;
  logic       hold_s;
  logic       err_s;
  logic       err_inc_s;
  logic       err_clr_s;

  // classify the current sample relative to the last accepted one
  always_comb begin
    low_s   = in_val[2:0];
    legal_s = is_legal(in_val[W-1:3] == {(W-3){1'b0}}, low_s);
    good_s  = legal_s && (low_s == succ(prev_r));
    hold_s  = legal_s && (prev_r == SEQ_S0) && (low_s == SEQ_S0);
    if (state_r == IDLE) begin
      err_s = ~legal_s;
    end else begin
      err_s = ~(good_s | hold_s);
    end
    err_inc_s = en & err_s;
    err_clr_s = en & clr_err;
  end

  sat_counter #(.N(ERR_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (err_inc_s),
    .clr (err_clr_s),
    .q   (err_count)
  );

  // checker FSM with registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      prev_r      <= 3'd0;
      run_r       <= 4'd0;
      locked      <= 1'b0;
      err_pulse   <= 1'b0;
      cycle_count <= {CYC_W{1'b0}};
      expected    <= 3'd0;
    end else if (!en) begin
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= err_s;
      case (state_r)
        IDLE: begin
          if (legal_s) begin
            state_r  <= HUNT;
            prev_r   <= low_s;
            run_r    <= 4'd0;
            expected <= succ(low_s);
          end else begin
            state_r <= IDLE;
          end
        end
        HUNT, LOCKED: begin
          if (good_s) begin
            prev_r   <= low_s;
            expected <= succ(low_s);
            if (state_r == HUNT) begin
              run_r <= run_r + 4'd1;
              if ((run_r + 4'd1) == LOCK_TGT) begin
                state_r <= LOCKED;
                locked  <= 1'b1;
              end else begin
                state_r <= HUNT;
              end
            end else if (prev_r == SEQ_S4) begin
              cycle_count <= cycle_count + CYC_W'(1);
            end else begin
              cycle_count <= cycle_count;
            end
          end else if (err_s) begin
            locked <= 1'b0;
            run_r  <= 4'd0;
            // a legal but wrong value restarts the hunt from that value
            if (legal_s) begin
              state_r  <= HUNT;
              prev_r   <= low_s;
              expected <= succ(low_s);
            end else begin
              state_r  <= IDLE;
              prev_r   <= 3'd0;
              expected <= 3'd0;
            end
          end else begin
            state_r <= state_r;
          end
        end
        default: begin
          state_r  <= IDLE;
          prev_r   <= 3'd0;
          run_r    <= 4'd0;
          locked   <= 1'b0;
          expected <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_checker.sv
// Directed bench for seq_checker with hand-computed expectations.
module tb_seq_checker;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] in_val;
  logic        clr_err;
  logic        locked;
  logic        err_pulse;
  logic [7:0]  err_count;
  logic [15:0] cycle_count;
  logic [2:0]  expected;

  int n_checks;
  int n_pass;

  seq_checker #(.W(32), .LOCK_CNT(3), .ERR_W(8), .CYC_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .in_val      (in_val),
    .clr_err     (clr_err),
    .locked      (locked),
    .err_pulse   (err_pulse),
    .err_count   (err_count),
    .cycle_count (cycle_count),
    .expected    (expected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [31:0] v, input logic e, input logic c);
    @(negedge clk);
    in_val  = v;
    en      = e;
    clr_err = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_locked"}, {31'd0, locked}, 32'd0);
    check({tag, "_pulse"},  {31'd0, err_pulse}, 32'd0);
    check({tag, "_errcnt"}, {24'd0, err_count}, 32'd0);
    check({tag, "_cyc"},    {16'd0, cycle_count}, 32'd0);
    check({tag, "_exp"},    {29'd0, expected}, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    en       = 1'b0;
    in_val   = 32'd0;
    clr_err  = 1'b0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // lock and first cycle wrap
    step(32'd0, 1'b1, 1'b0);
    check("idle_to_hunt_exp", {29'd0, expected}, 32'd2);
    check("hunt_unlocked", {31'd0, locked}, 32'd0);
    step(32'd2, 1'b1, 1'b0);
    step(32'd5, 1'b1, 1'b0);
    check("two_good_unlocked", {31'd0, locked}, 32'd0);
    step(32'd3, 1'b1, 1'b0);
    check("lock_after_3", {31'd0, locked}, 32'd1);
    check("lock_exp", {29'd0, expected}, 32'd4);
    step(32'd4, 1'b1, 1'b0);
    check("cyc_before_wrap", {16'd0, cycle_count}, 32'd0);
    step(32'd0, 1'b1, 1'b0);
    check("cyc_wrap1", {16'd0, cycle_count}, 32'd1);
    step(32'd2, 1'b1, 1'b0);
    check("no_err_phase1", {24'd0, err_count}, 32'd0);

    // illegal value while locked
    step(32'd6, 1'b1, 1'b0);
    check("ill_pulse", {31'd0, err_pulse}, 32'd1);
    check("ill_cnt", {24'd0, err_count}, 32'd1);
    check("ill_unlock", {31'd0, locked}, 32'd0);
    check("ill_exp", {29'd0, expected}, 32'd0);
    step(32'd7, 1'b0, 1'b0);
    check("en0_pulse_drop", {31'd0, err_pulse}, 32'd0);
    check("en0_cnt_hold", {24'd0, err_count}, 32'd1);
    step(32'd0, 1'b1, 1'b0);
    check("relock_start_exp", {29'd0, expected}, 32'd2);
    step(32'd2, 1'b1, 1'b0);
    step(32'd5, 1'b1, 1'b0);
    step(32'd3, 1'b1, 1'b0);
    check("relock", {31'd0, locked}, 32'd1);

    // hold of zero while locked
    step(32'd4, 1'b1, 1'b0);
    step(32'd0, 1'b1, 1'b0);
    check("cyc_wrap2", {16'd0, cycle_count}, 32'd2);
    for (int i = 0; i < 5; i++) begin
      step(32'd0, 1'b1, 1'b0);
      check("hold_no_pulse", {31'd0, err_pulse}, 32'd0);
    end
    check("hold_locked", {31'd0, locked}, 32'd1);
    check("hold_cyc", {16'd0, cycle_count}, 32'd2);
    step(32'd2, 1'b1, 1'b0);
    check("resume_locked", {31'd0, locked}, 32'd1);
    check("resume_cnt", {24'd0, err_count}, 32'd1);

    // repeated value, then upper bits set
    step(32'd5, 1'b1, 1'b0);
    step(32'd5, 1'b1, 1'b0);
    check("rep_pulse", {31'd0, err_pulse}, 32'd1);
    check("rep_cnt", {24'd0, err_count}, 32'd2);
    check("rep_unlock", {31'd0, locked}, 32'd0);
    check("rep_exp", {29'd0, expected}, 32'd3);
    step(32'h0000_0102, 1'b1, 1'b0);
    check("upper_pulse", {31'd0, err_pulse}, 32'd1);
    check("upper_cnt", {24'd0, err_count}, 32'd3);
    check("upper_exp", {29'd0, expected}, 32'd0);

    // saturation and clear
    for (int i = 0; i < 260; i++) begin
      step(32'd7, 1'b1, 1'b0);
    end
    check("sat_cnt", {24'd0, err_count}, 32'd255);
    check("sat_pulse", {31'd0, err_pulse}, 32'd1);
    step(32'd7, 1'b1, 1'b1);
    check("clr_with_err", {24'd0, err_count}, 32'd1);
    step(32'd0, 1'b1, 1'b1);
    check("clr_alone", {24'd0, err_count}, 32'd0);
    check("clr_alone_pulse", {31'd0, err_pulse}, 32'd0);
    check("clr_alone_exp", {29'd0, expected}, 32'd2);

    // asynchronous reset while locked
    step(32'd2, 1'b1, 1'b0);
    step(32'd5, 1'b1, 1'b0);
    step(32'd3, 1'b1, 1'b0);
    step(32'd4, 1'b1, 1'b0);
    step(32'd0, 1'b1, 1'b0);
    check("pre_rst_locked", {31'd0, locked}, 32'd1);
    check("pre_rst_cyc", {16'd0, cycle_count}, 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    in_val = 32'd2;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check_all_zero("post_rst_en0");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
